baseerat_update_pipeline: RTL
=============================

# baseerat_update_pipeline

Parametrised successor to the M-stage update shift register. Carries DATA_WIDTH-bit words through PIPELINE_STAGES registered stages with a per-stage valid bit, a global advance enable (stall), and per-stage in-place overwrite from a shared update bus. It also provides a registered occupancy count. It sits between a producer that injects words and a consumer that samples the last stage, and it lets a side agent patch any in-flight word.

## Interface
Parameters:
- DATA_WIDTH, 256, word width in bits (≥1)
- PIPELINE_STAGES, 32, number of stages (≥2)
- CNT_WIDTH, $clog2(PIPELINE_STAGES+1), occupancy counter width (derived; do not override)

Ports:
- clock  input  1  single clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- shift_en  input  1  advance all stages by one this cycle
- in_valid  input  1  din carries a word (sampled only when shift_en=1)
- din  input  DATA_WIDTH  word entering stage 0
- update  input  PIPELINE_STAGES  per-stage overwrite mask, bit g targets stage g
- udin  input  DATA_WIDTH  overwrite value, shared by all stages
- flush  input  1  clear all valid bits (present only with BASEERAT_UPDPIPE_FLUSH_EN)
- out_valid  output  1  valid bit of stage PIPELINE_STAGES-1
- dout  output  DATA_WIDTH  data of stage PIPELINE_STAGES-1
- out_take  output  1  combinational shift_en & out_valid: the consumer owns dout this cycle
- count  output  CNT_WIDTH  registered number of valid stages

## Operation
- Each stage g holds data_g and valid_g. The source of stage g is stage g-1 for g>0, and {in_valid, din} for g=0.
- Stage-g next state, with the first matching rule applied:
  1. reset: valid 0, data 0.
  2. flush (macro enabled): valid 0, data holds.
  3. update[g]=1: data udin, valid 1. This applies regardless of shift_en.
  4. shift_en=1: {valid, data} ← source.
  5. otherwise: hold.
- Update with shift in the same cycle: udin lands in stage g, and the word that would have shifted into stage g is discarded. The old stage-g content still moves to stage g+1 unless update[g+1] is set.
- An update to an empty stage creates a valid word (injection mid-pipe).
- Data of invalid stages is don't-care except for the reset value. Implementations must not gate the data registers on valid.
- When shift_en=1, the stage PIPELINE_STAGES-1 word leaves the pipeline. There is no backpressure path; the consumer must take it when out_take=1.
- count equals the popcount of the next-state valid vector, registered. It is always equal to the number of set valid bits, and it saturates only by construction at PIPELINE_STAGES.

## Timing
- Reset values: out_valid=0, dout=0, count=0. out_take=0 while reset state holds.
- Latency: a word accepted at edge N (shift_en=1, in_valid=1) appears on dout after PIPELINE_STAGES edges with shift_en=1. The minimum is PIPELINE_STAGES cycles. Stall cycles add 1 each.
- Update latency: 1 cycle. For update[PIPELINE_STAGES-1], dout=udin the cycle after.
- out_valid, dout, and count are registered. out_take is combinational from shift_en.
- Full condition (count=PIPELINE_STAGES) and empty condition (count=0) impose no restriction. Input is accepted whenever shift_en=1.
- Reset mid-operation: all in-flight words are lost on the edge where reset=1. reset overrides shift_en, update, and flush.

## Configuration
- BASEERAT_UPDPIPE_FLUSH_EN defined: the flush port exists with the priority described above. Flush and update on the same stage in the same cycle leave that stage invalid. count is 0 the cycle after flush.
- Not defined: no flush port, and rule 2 is absent. Behaviour is otherwise identical.

## Test plan
- Reset, then 4 words 0xA1..0xA4 with shift_en=1 and PIPELINE_STAGES=8 -> 0xA1 on dout with out_valid=1 exactly 8 cycles after its accept. count reaches 4 and stays at 4 until the first word exits.
- Stream 0x10 with shift_en toggling 1,0,1,0 -> word exits after 8 shift edges (15 cycles). Data holds during stall. out_take=0 on stall cycles.
- Pipe full of valids, update[3]=1 with udin=0x55 while shifting -> the word that would enter stage 3 is dropped. 0x55 exits 5 shifts later. count is unchanged.
- Empty pipe, update[7]=1 with udin=0xEE and shift_en=0 -> next cycle out_valid=1, dout=0xEE, count=1.
- Pipe holding 6 words, reset pulsed for 1 cycle mid-stream -> next cycle out_valid=0, dout=0, count=0. No stale word ever emerges afterwards.
- With BASEERAT_UPDPIPE_FLUSH_EN: 5 valid words, flush=1 and update[2]=1 in the same cycle -> count=0 and no valid outputs for the following 8 shifts.

Source files
------------

// File: rtl/baseerat_update_pipeline_if.sv
// ---------------------------------------------------------------------------
// baseerat_update_pipeline_if
//
// Purpose: bundles the producer, patch and consumer signals of the
// baseerat_update_pipeline. The master side is the environment (producer,
// side agent and consumer). The slave side is the pipeline itself.
//
// Parameters:
//   DATA_WIDTH      word width in bits
//   PIPELINE_STAGES number of pipeline stages
//   CNT_WIDTH       occupancy counter width (derived, leave at default)
//
// Signals:
//   shift_en   master->slave  advance every stage by one this cycle
//   in_valid   master->slave  din carries a word (used only when shift_en=1)
//   din        master->slave  word entering stage 0
//   update     master->slave  per-stage overwrite mask, bit g targets stage g
//   udin       master->slave  overwrite value, shared by all stages
//   flush      master->slave  clear all valid bits (BASEERAT_UPDPIPE_FLUSH_EN only)
//   out_valid  slave->master  valid bit of the last stage
//   dout       slave->master  data of the last stage
//   out_take   slave->master  consumer owns dout this cycle
//   count      slave->master  registered number of valid stages
//
// Optional feature macro: BASEERAT_UPDPIPE_FLUSH_EN (adds the flush signal).
// ---------------------------------------------------------------------------
interface baseerat_update_pipeline_if #(
  parameter int DATA_WIDTH      = 256,
  parameter int PIPELINE_STAGES = 32,
  parameter int CNT_WIDTH       = $clog2(PIPELINE_STAGES + 1)
);

  logic                       shift_en;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      din;
  logic [PIPELINE_STAGES-1:0] update;
  logic [DATA_WIDTH-1:0]      udin;
`ifdef BASEERAT_UPDPIPE_FLUSH_EN
  logic                       flush;
`endif
  logic                       out_valid;
  logic [DATA_WIDTH-1:0]      dout;
  logic                       out_take;
  logic [CNT_WIDTH-1:0]       count;

  // The flush signal only exists in the flush-enabled build, so each
  // modport is declared in full for both builds.
`ifdef BASEERAT_UPDPIPE_FLUSH_EN
  modport master (
    output shift_en, in_valid, din, update, udin, flush,
    input  out_valid, dout, out_take, count
  );

  modport slave (
    input  shift_en, in_valid, din, update, udin, flush,
    output out_valid, dout, out_take, count
  );
`else
  modport master (
    output shift_en, in_valid, din, update, udin,
    input  out_valid, dout, out_take, count
  );

  modport slave (
    input  shift_en, in_valid, din, update, udin,
    output out_valid, dout, out_take, count
  );
`endif

endinterface

// File: rtl/baseerat_update_pipeline.sv
// ---------------------------------------------------------------------------
// baseerat_update_pipeline
//
// Purpose: a PIPELINE_STAGES deep register pipeline of DATA_WIDTH-bit words.
// Every stage carries its own valid bit. A global shift enable advances all
// stages together. A shared update bus can overwrite any in-flight stage,
// or inject a word into an empty stage. A registered occupancy count tracks
// how many stages hold valid words.
//
// Ports:
//   clock  single clock, all state changes on its rising edge
//   reset  synchronous, active-high; clears every valid bit, data word and
//          the count, and overrides shift, update and flush
//   bus    baseerat_update_pipeline_if.slave
//            inputs : shift_en, in_valid, din, update, udin, (flush)
//            outputs: out_valid, dout, out_take, count
//
// Stage-g next-state priority, highest first:
//   reset -> flush -> update[g] -> shift_en -> hold
//
// Optional feature macro: BASEERAT_UPDPIPE_FLUSH_EN
//   defined   : bus.flush clears every valid bit and leaves the data in place.
//               Flush beats an update to the same stage.
//   undefined : no flush signal, and the flush rule is absent.
// ---------------------------------------------------------------------------
module baseerat_update_pipeline #(
  parameter int DATA_WIDTH      = 256,
  parameter int PIPELINE_STAGES = 32,
  parameter int CNT_WIDTH       = $clog2(PIPELINE_STAGES + 1)
) (
  input logic                    clock,
  input logic                    reset,
  baseerat_update_pipeline_if.slave bus
);

  // Per-stage state and its next value
  logic [PIPELINE_STAGES-1:0] valid_q;
  logic [PIPELINE_STAGES-1:0] valid_next;
  logic [DATA_WIDTH-1:0]      data_q    [PIPELINE_STAGES];
  logic [DATA_WIDTH-1:0]      data_next [PIPELINE_STAGES];

  // Word each stage would receive on a shift
  logic [PIPELINE_STAGES-1:0] src_valid;
  logic [DATA_WIDTH-1:0]      src_data  [PIPELINE_STAGES];

  // Occupancy count and its next value
  logic [CNT_WIDTH-1:0]       count_q;
  logic [CNT_WIDTH-1:0]       count_next;

  // Internal flush request; tied low when the feature is compiled out
  logic                       flush_req;

`ifdef BASEERAT_UPDPIPE_FLUSH_EN
  assign flush_req = bus.flush;
`else
  assign flush_req = 1'b0;
`endif

  // Shift sources: stage 0 takes the producer word, and every later stage
  // takes the word in the stage just before it. The valid vector is a plain
  // left shift with in_valid entering at the bottom.
  always_comb begin
    src_valid   = {valid_q[PIPELINE_STAGES-2:0], bus.in_valid};
    src_data[0] = bus.din;
    for (int g = 1; g < PIPELINE_STAGES; g++) begin
      src_data[g] = data_q[g-1];
    end
  end

  // Stage next-state selection. Each stage first defaults to holding its
  // content. Flush clears only the valid bits, so data stays where it is.
  // An update then overwrites the stage and marks it valid, whether or not
  // the pipe is shifting. This means the word that would have shifted into
  // an updated stage is simply dropped. A shift is applied last. Data is
  // never gated on valid: invalid stages still move their stale data along.
  always_comb begin
    for (int g = 0; g < PIPELINE_STAGES; g++) begin
      valid_next[g] = valid_q[g];
      data_next[g]  = data_q[g];
      if (flush_req) begin
        valid_next[g] = 1'b0;
      end else if (bus.update[g]) begin
        valid_next[g] = 1'b1;
        data_next[g]  = bus.udin;
      end else if (bus.shift_en) begin
        valid_next[g] = src_valid[g];
        data_next[g]  = src_data[g];
      end
    end
  end

  // The occupancy count is the population count of the next valid vector.
  // Registering it keeps it exactly in step with the valid bits. It cannot
  // exceed PIPELINE_STAGES, because there are only that many bits.
  always_comb begin
    count_next = '0;
    for (int g = 0; g < PIPELINE_STAGES; g++) begin
      count_next = count_next + CNT_WIDTH'(valid_next[g]);
    end
  end

  // State registers. Reset wins over every other request and clears the
  // data as well as the valid bits, so dout reads zero straight after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int g = 0; g < PIPELINE_STAGES; g++) begin
        data_q[g] <= '0;
      end
    end else begin
      valid_q <= valid_next;
      count_q <= count_next;
      for (int g = 0; g < PIPELINE_STAGES; g++) begin
        data_q[g] <= data_next[g];
      end
    end
  end

  // Consumer view of the last stage. out_take is the only combinational
  // output. The word is gone on this edge, so the consumer must grab it now.
  assign bus.out_valid = valid_q[PIPELINE_STAGES-1];
  assign bus.dout      = data_q[PIPELINE_STAGES-1];
  assign bus.out_take  = bus.shift_en & valid_q[PIPELINE_STAGES-1];
  assign bus.count     = count_q;

endmodule
